// File: rtl/clk_divider_prog_if.sv
// Control/status bundle for the programmable clock divider.
// The master side drives enable, restart and load requests; the slave side returns the divided outputs.
interface clk_divider_prog_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic             clr;
  logic             div_load;
  logic [CNT_W-1:0] div_val;
  logic [CNT_W-1:0] hi_val;
  logic             O_CLK;
  logic             O_TICK;
  logic             load_pend;
  logic             load_err;
  logic [CNT_W-1:0] cur_div;

  modport master (
    output en, clr, div_load, div_val, hi_val,
    input  O_CLK, O_TICK, load_pend, load_err, cur_div
  );

  modport slave (
    input  en, clr, div_load, div_val, hi_val,
    output O_CLK, O_TICK, load_pend, load_err, cur_div
  );
endinterface

// File: rtl/clk_divider_prog.sv
// Runtime-programmable clock divider with a per-period tick strobe.
// New period/high-time settings wait in a shadow register and take effect at the next period boundary.
module clk_divider_prog #(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 20
) (
  input logic               I_CLK,
  input logic               rst,
  clk_divider_prog_if.slave bus
);

  localparam logic [CNT_W-1:0] ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] TWO    = {{(CNT_W-2){1'b0}}, 2'b10};
  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] DEF_HI  = DEF_DIV >> 1;

  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [CNT_W-1:0] div_act_q,  div_act_d;
  logic [CNT_W-1:0] hi_act_q,   hi_act_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic [CNT_W-1:0] pend_hi_q,  pend_hi_d;
  logic             load_pend_q, load_pend_d;
  logic             load_err_q,  load_err_d;
  logic             o_clk_q,     o_clk_d;
  logic             o_tick_q,    o_tick_d;

  logic             load_ok_s;
  logic             wrap_s;
  logic [CNT_W-1:0] load_hi_s;
  logic [CNT_W-1:0] cnt_n_s;

  // Load validation and free-running counter successor
  always_comb begin
    load_ok_s = (bus.div_val >= TWO) &&
                ((bus.hi_val == ZERO) || (bus.hi_val < bus.div_val));
    load_hi_s = (bus.hi_val == ZERO) ? (bus.div_val >> 1) : bus.hi_val;
    wrap_s    = (cnt_q == (div_act_q - ONE));
    cnt_n_s   = wrap_s ? ZERO : (cnt_q + ONE);
  end

  // Next-state: clr restarts (applying pending), en counts, a load always lands in the shadow
  always_comb begin
    cnt_d       = cnt_q;
    div_act_d   = div_act_q;
    hi_act_d    = hi_act_q;
    pend_div_d  = pend_div_q;
    pend_hi_d   = pend_hi_q;
    load_pend_d = load_pend_q;
    load_err_d  = 1'b0;
    o_clk_d     = o_clk_q;
    o_tick_d    = 1'b0;

    if (bus.clr) begin
      if (load_pend_q) begin
        div_act_d   = pend_div_q;
        hi_act_d    = pend_hi_q;
        load_pend_d = 1'b0;
      end else begin
        load_pend_d = load_pend_q;
      end
      cnt_d   = div_act_d - ONE;
      o_clk_d = 1'b0;
    end else if (bus.en) begin
      if (wrap_s && load_pend_q) begin
        div_act_d   = pend_div_q;
        hi_act_d    = pend_hi_q;
        load_pend_d = 1'b0;
      end else begin
        load_pend_d = load_pend_q;
      end
      cnt_d    = cnt_n_s;
      o_clk_d  = (cnt_n_s < hi_act_d);
      o_tick_d = (cnt_n_s == ZERO);
    end else begin
      cnt_d = cnt_q;
    end

    // Captured after the apply decision so a same-edge load waits for the next boundary
    if (bus.div_load) begin
      if (load_ok_s) begin
        pend_div_d  = bus.div_val;
        pend_hi_d   = load_hi_s;
        load_pend_d = 1'b1;
      end else begin
        load_err_d = 1'b1;
      end
    end else begin
      load_err_d = 1'b0;
    end
  end

  // State registers; reset parks the counter in the last cycle of a period
  always_ff @(posedge I_CLK or posedge rst) begin
    if (rst) begin
      cnt_q       <= DEF_DIV - ONE;
      div_act_q   <= DEF_DIV;
      hi_act_q    <= DEF_HI;
      pend_div_q  <= DEF_DIV;
      pend_hi_q   <= DEF_HI;
      load_pend_q <= 1'b0;
      load_err_q  <= 1'b0;
      o_clk_q     <= 1'b0;
      o_tick_q    <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      div_act_q   <= div_act_d;
      hi_act_q    <= hi_act_d;
      pend_div_q  <= pend_div_d;
      pend_hi_q   <= pend_hi_d;
      load_pend_q <= load_pend_d;
      load_err_q  <= load_err_d;
      o_clk_q     <= o_clk_d;
      o_tick_q    <= o_tick_d;
    end
  end

  assign bus.O_CLK     = o_clk_q;
  assign bus.O_TICK    = o_tick_q;
  assign bus.load_pend = load_pend_q;
  assign bus.load_err  = load_err_q;
  assign bus.cur_div   = div_act_q;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Scoreboard bench for clk_divider_prog: each driven cycle queues the outputs expected after that edge,
// and a monitor pops and compares them one time unit after every rising edge.
module tb_clk_divider_prog;

  localparam int W = 16;

  logic I_CLK = 1'b0;
  logic rst   = 1'b1;

  always #5 I_CLK = ~I_CLK;

  clk_divider_prog_if #(.CNT_W(W)) bus ();

  clk_divider_prog #(.CNT_W(W), .DEFAULT_DIV(20)) dut (
    .I_CLK (I_CLK),
    .rst   (rst),
    .bus   (bus)
  );

  typedef struct {
    logic         clk;
    logic         tick;
    logic         pend;
    logic         err;
    logic [W-1:0] div;
    string        tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: observed %0d, expected %0d", tag, got, want);
  endtask

  // Compare the oldest queued expectation against the outputs just after each edge
  always @(posedge I_CLK) begin : monitor
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq({e.tag, ".clk"},  W'(bus.O_CLK),     W'(e.clk));
      check_eq({e.tag, ".tick"}, W'(bus.O_TICK),    W'(e.tick));
      check_eq({e.tag, ".pend"}, W'(bus.load_pend), W'(e.pend));
      check_eq({e.tag, ".err"},  W'(bus.load_err),  W'(e.err));
      check_eq({e.tag, ".div"},  bus.cur_div,       e.div);
    end
  end

  task automatic step(input logic e, input logic c, input logic ld,
                      input logic [W-1:0] dv, input logic [W-1:0] hv,
                      input logic x_clk, input logic x_tick, input logic x_pend,
                      input logic x_err, input logic [W-1:0] x_div, input string tag);
    exp_t x;
    @(negedge I_CLK);
    bus.en       = e;
    bus.clr      = c;
    bus.div_load = ld;
    bus.div_val  = dv;
    bus.hi_val   = hv;
    x.clk  = x_clk;
    x.tick = x_tick;
    x.pend = x_pend;
    x.err  = x_err;
    x.div  = x_div;
    x.tag  = tag;
    exp_q.push_back(x);
  endtask

  // Whole periods starting at a boundary: high for hi cycles from the wrap, tick on the first
  task automatic run_periods(input int n, input int div, input int hi, input string tag);
    for (int p = 0; p < n; p++)
      for (int i = 0; i < div; i++)
        step(1'b1, 1'b0, 1'b0, 16'd0, 16'd0, (i < hi), (i == 0), 1'b0, 1'b0, W'(div), tag);
  endtask

  initial begin
    bus.en = 1'b0; bus.clr = 1'b0; bus.div_load = 1'b0;
    bus.div_val = 16'd0; bus.hi_val = 16'd0;
    rst = 1'b1;
    repeat (2) @(posedge I_CLK);
    #1;
    check_eq("rst.clk",  W'(bus.O_CLK),     16'd0);
    check_eq("rst.tick", W'(bus.O_TICK),    16'd0);
    check_eq("rst.pend", W'(bus.load_pend), 16'd0);
    check_eq("rst.err",  W'(bus.load_err),  16'd0);
    check_eq("rst.div",  bus.cur_div,       16'd20);
    @(negedge I_CLK);
    rst = 1'b0;

    // Default divide-by-20, first edge after release starts a period
    run_periods(2, 20, 10, "def20");

    // Load 5/auto at cnt=4; current period completes unchanged
    for (int i = 0; i < 20; i++)
      step(1'b1, 1'b0, (i == 4), 16'd5, 16'd0, (i < 10), (i == 0), (i >= 4), 1'b0, 16'd20, "ld5");
    run_periods(2, 5, 2, "div5");

    // Second load overwrites the first before the boundary
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b0, (i == 1) || (i == 3), (i == 1) ? 16'd3 : 16'd7, (i == 1) ? 16'd1 : 16'd3,
           (i < 2), (i == 0), (i >= 1), 1'b0, 16'd5, "ld7");
    run_periods(2, 7, 3, "div7");

    // Rejected loads: divisor below 2, and high time not below divisor
    for (int i = 0; i < 7; i++)
      step(1'b1, 1'b0, (i == 1) || (i == 3), (i == 1) ? 16'd1 : 16'd8, (i == 1) ? 16'd0 : 16'd8,
           (i < 3), (i == 0), 1'b0, (i == 1) || (i == 3), 16'd7, "lderr");
    run_periods(1, 7, 3, "div7b");

    // Load on the wrap edge itself waits a full period
    for (int i = 0; i < 7; i++)
      step(1'b1, 1'b0, (i == 0), 16'd20, 16'd0, (i < 3), (i == 0), 1'b1, 1'b0, 16'd7, "ldwrap");

    // en stall at cnt=5 for 7 cycles; a load during the stall is still captured
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 1'b1, (i == 0), 1'b0, 1'b0, 16'd20, "prestall");
    for (int k = 0; k < 7; k++)
      step(1'b0, 1'b0, (k == 3), 16'd20, 16'd0, 1'b1, 1'b0, (k >= 3), 1'b0, 16'd20, "stall");
    for (int i = 6; i < 20; i++)
      step(1'b1, 1'b0, 1'b0, 16'd0, 16'd0, (i < 10), 1'b0, 1'b1, 1'b0, 16'd20, "poststall");

    // Async reset at cnt=3 with a pending value that must be discarded
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, (i == 2), 16'd4, 16'd0, 1'b1, (i == 0), (i >= 2), 1'b0, 16'd20, "prerst");
    @(negedge I_CLK);
    #2;
    rst = 1'b1;
    bus.en = 1'b0;
    #1;
    check_eq("arst.clk",  W'(bus.O_CLK),     16'd0);
    check_eq("arst.tick", W'(bus.O_TICK),    16'd0);
    check_eq("arst.pend", W'(bus.load_pend), 16'd0);
    check_eq("arst.div",  bus.cur_div,       16'd20);
    @(negedge I_CLK);
    rst = 1'b0;
    run_periods(1, 20, 10, "postrst");

    // clr applies a pending div=4 immediately
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b0, (i == 2), 16'd4, 16'd0, 1'b1, (i == 0), (i >= 2), 1'b0, 16'd20, "preclr");
    step(1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4, "clr");
    run_periods(2, 4, 2, "div4");

    // clr with a simultaneous load: load stays pending, then applies on the next wrap
    step(1'b1, 1'b1, 1'b1, 16'd6, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd4, "clrld");
    run_periods(1, 6, 3, "div6");

    @(negedge I_CLK);
    @(posedge I_CLK);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
